datapath: RTL and testbench

//  Datapath executed by the microprogrammed control unit, which sits directly upstream of it.

---
 rtl/dp_pkg.sv | 13 +
 rtl/dp_if.sv | 28 ++
 rtl/dp_alu.sv | 34 +++
 rtl/datapath.sv | 67 ++++++
 tb/tb_datapath.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the datapath and the microprogrammed control unit,
// so microcode fields decode identically on both sides.
package dp_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int DP_WIDTH   = 8;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_AND   = 2'b10,
    ALU_PASSA = 2'b11
  } alu_op_e;
endpackage

// File: rtl/dp_if.sv
// Control-unit <-> datapath bus: microinstruction fields in, data and flags out.
interface dp_if #(parameter int WIDTH = dp_pkg::DP_WIDTH);
  import dp_pkg::*;

  logic [REG_ADDR_W-1:0] fld_A;
  logic [REG_ADDR_W-1:0] fld_B;
  logic [REG_ADDR_W-1:0] fld_C;
  logic                  ldRF;
  logic                  selR_in;
  logic                  ldR_in;
  logic                  ldR_out;
  alu_op_e               alu_op;
  logic [WIDTH-1:0]      data_in;
  logic [WIDTH-1:0]      data_out;
  logic                  cy;
  logic                  neg;
  logic                  zero;

  modport master (
    output fld_A, fld_B, fld_C, ldRF, selR_in, ldR_in, ldR_out, alu_op, data_in,
    input  data_out, cy, neg, zero
  );

  modport slave (
    input  fld_A, fld_B, fld_C, ldRF, selR_in, ldR_in, ldR_out, alu_op, data_in,
    output data_out, cy, neg, zero
  );
endinterface

// File: rtl/dp_alu.sv
// Combinational ALU evaluated at WIDTH+1 bits so the carry falls out of the top bit.
module dp_alu
  import dp_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] res,
  output logic             cy_next,
  output logic             neg_next,
  output logic             zero_next
);

  logic [WIDTH:0] sum;

  // SUB as A + ~B + 1: carry out set means no borrow (A >= B unsigned).
  always_comb begin
    sum = '0;
    case (op)
      ALU_ADD: sum = {1'b0, a} + {1'b0, b};
      ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      ALU_AND: sum = {1'b0, a & b};
      default: sum = {1'b0, a};
    endcase
  end

  assign res       = sum[WIDTH-1:0];
  assign cy_next   = sum[WIDTH];
  assign neg_next  = sum[WIDTH-1];
  assign zero_next = (sum[WIDTH-1:0] == '0);

endmodule

// File: rtl/datapath.sv
// Datapath driven by the microprogrammed control unit: 8-entry RF, ALU,
// R_in/R_out and registered cy/neg/zero flags used for microcode branches.
module datapath
  import dp_pkg::*;
#(
  parameter int WIDTH    = DP_WIDTH,
  parameter int RF_DEPTH = 8          // at most 2**REG_ADDR_W
) (
  input  logic clk,
  input  logic rst_n,
  dp_if.slave  bus
);

  logic [WIDTH-1:0] rf [RF_DEPTH];
  logic [WIDTH-1:0] r_in;
  logic [WIDTH-1:0] r_out;
  logic             cy_q, neg_q, zero_q;

  logic [WIDTH-1:0] op_a, op_b, alu_res;
  logic             cy_next, neg_next, zero_next;
  logic             flag_upd;
  logic             wr_ok;

  // No write-to-read bypass: a same-cycle read of fld_C sees the old entry.
  assign op_a  = (32'(bus.fld_A) < RF_DEPTH) ? rf[bus.fld_A] : '0;
  assign op_b  = (32'(bus.fld_B) < RF_DEPTH) ? rf[bus.fld_B] : '0;
  assign wr_ok = (32'(bus.fld_C) < RF_DEPTH);

  dp_alu #(.WIDTH(WIDTH)) u_alu (
    .a         (op_a),
    .b         (op_b),
    .op        (bus.alu_op),
    .res       (alu_res),
    .cy_next   (cy_next),
    .neg_next  (neg_next),
    .zero_next (zero_next)
  );

  // Flags only move when the ALU result is actually consumed.
  assign flag_upd = (bus.ldRF & ~bus.selR_in) | bus.ldR_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
      r_in   <= '0;
      r_out  <= '0;
      cy_q   <= 1'b0;
      neg_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (bus.ldRF && wr_ok) rf[bus.fld_C] <= bus.selR_in ? r_in : alu_res;
      if (bus.ldR_in)        r_in          <= bus.data_in;
      if (bus.ldR_out)       r_out         <= alu_res;
      if (flag_upd) begin
        cy_q   <= cy_next;
        neg_q  <= neg_next;
        zero_q <= zero_next;
      end
    end
  end

  assign bus.data_out = r_out;
  assign bus.cy       = cy_q;
  assign bus.neg      = neg_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: expected R_out/flag snapshots are queued as
// microinstructions are driven and compared when the DUT's registers update.
module tb_datapath;
  import dp_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dp_if bus ();

  datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       cy;
    logic       neg;
    logic       zero;
  } obs_t;

  obs_t       sb [$];
  logic [7:0] m_rf [8];
  logic [7:0] m_rin, m_rout;
  logic       m_cy, m_neg, m_zero;
  int         checks = 0;
  int         errors = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference ALU written from the arithmetic definition: {carry, result}.
  function automatic logic [8:0] alu_model(input logic [7:0] a, b, input logic [1:0] op);
    case (op)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {(a >= b), 8'(a - b)};
      2'd2:    return {1'b0, a & b};
      default: return {1'b0, a};
    endcase
  endfunction

  function automatic obs_t dut_obs();
    return {bus.data_out, bus.cy, bus.neg, bus.zero};
  endfunction

  function automatic obs_t mdl_obs();
    return {m_rout, m_cy, m_neg, m_zero};
  endfunction

  // Drive one microinstruction across one edge and advance the model.
  task automatic step(input logic [2:0] a, b, c, input logic ld_rf, sel, ld_rin, ld_rout,
                      input logic [1:0] op, input logic [7:0] din);
    logic [8:0] r;
    logic       rst;
    logic [7:0] old_rin;
    bus.fld_A = a; bus.fld_B = b; bus.fld_C = c;
    bus.ldRF = ld_rf; bus.selR_in = sel; bus.ldR_in = ld_rin; bus.ldR_out = ld_rout;
    bus.alu_op = alu_op_e'(op); bus.data_in = din;
    r       = alu_model(m_rf[a], m_rf[b], op);
    rst     = rst_n;
    old_rin = m_rin;
    @(posedge clk);
    if (!rst) begin
      foreach (m_rf[i]) m_rf[i] = 8'h00;
      m_rin = 8'h00; m_rout = 8'h00; m_cy = 1'b0; m_neg = 1'b0; m_zero = 1'b0;
    end else begin
      if ((ld_rf && !sel) || ld_rout) begin
        m_cy = r[8]; m_neg = r[7]; m_zero = (r[7:0] == 8'h00);
      end
      if (ld_rf)   m_rf[c] = sel ? old_rin : r[7:0];
      if (ld_rin)  m_rin   = din;
      if (ld_rout) m_rout  = r[7:0];
    end
    #1;
    bus.ldRF = 1'b0; bus.selR_in = 1'b0; bus.ldR_in = 1'b0; bus.ldR_out = 1'b0;
    if (rst && ld_rout) sb.push_back(mdl_obs());
  endtask

  task automatic load_reg(input logic [2:0] c, input logic [7:0] val);
    step(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, val);
    step(3'd0, 3'd0, c,    1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic read_reg(input logic [2:0] a);
    step(a, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00);
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0;
    step(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) load_reg(3'(i), 8'h5A);
    step(3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'hC3);
    read_reg(3'd3);
    o = sb.pop_front();
    checks++;
    if (dut_obs() !== o || bus.data_out !== 8'h5A) begin
      errors++; $display("FAIL preload: got %h need %h", dut_obs(), o);
    end
    // Reset while every strobe is asserted.
    rst_n = 1'b0;
    step(3'd3, 3'd3, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 8'hFF);
    rst_n = 1'b1;
    checks++;
    if (bus.data_out !== 8'h00 || bus.cy !== 1'b0 || bus.neg !== 1'b0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got d=%h cy=%b neg=%b zero=%b need 00 0 0 0",
               bus.data_out, bus.cy, bus.neg, bus.zero);
    end
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i));
      o = sb.pop_front();
      checks++;
      if (dut_obs() !== o || bus.data_out !== 8'h00) begin
        errors++; $display("FAIL reset_rf%0d: got %h need %h", i, dut_obs(), o);
      end
    end
    // R_in must have cleared too.
    step(3'd0, 3'd0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    read_reg(3'd6);
    o = sb.pop_front();
    checks++;
    if (dut_obs() !== o || bus.data_out !== 8'h00) begin
      errors++; $display("FAIL reset_rin: got %h need %h", dut_obs(), o);
    end
  endtask

  task automatic test_load_path();
    obs_t o;
    step(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h05);
    step(3'd0, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    read_reg(3'd2);
    o = sb.pop_front();
    checks++;
    if (dut_obs() !== o || bus.data_out !== 8'h05 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL load_path: got %h need %h", dut_obs(), o);
    end
  endtask

  task automatic test_add_carry();
    obs_t o;
    load_reg(3'd1, 8'hF0);
    load_reg(3'd2, 8'h20);
    step(3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    checks++;
    if (bus.cy !== 1'b1 || bus.neg !== 1'b0 || bus.zero !== 1'b0) begin
      errors++; $display("FAIL add_flags: got cy=%b neg=%b zero=%b need 1 0 0",
                         bus.cy, bus.neg, bus.zero);
    end
    read_reg(3'd3);
    o = sb.pop_front();
    checks++;
    if (dut_obs() !== o || bus.data_out !== 8'h10) begin
      errors++; $display("FAIL add_result: got %h need %h", dut_obs(), o);
    end
  endtask

  task automatic test_sub();
    obs_t o;
    load_reg(3'd5, 8'h33);
    step(3'd5, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    o = sb.pop_front();
    checks++;
    if (dut_obs() !== o || dut_obs() !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sub_equal: got %h need %h", dut_obs(), o);
    end
    load_reg(3'd6, 8'h01);
    load_reg(3'd7, 8'h02);
    step(3'd6, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00);
    o = sb.pop_front();
    checks++;
    if (dut_obs() !== o || dut_obs() !== {8'hFF, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_borrow: got %h need %h", dut_obs(), o);
    end
  endtask

  task automatic test_flag_hold();
    for (int i = 0; i < 3; i++) begin
      step(3'd1, 3'd2, 3'(i), 1'b0, 1'b0, 1'b0, 1'b0, 2'(i), 8'h00);
      checks++;
      if (dut_obs() !== {8'hFF, 1'b0, 1'b1, 1'b0}) begin
        errors++; $display("FAIL hold_idle%0d: got %h need ff_0_1_0", i, dut_obs());
      end
    end
    step(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h44);
    step(3'd1, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    checks++;
    if (dut_obs() !== {8'hFF, 1'b0, 1'b1, 1'b0} || dut_obs() !== mdl_obs()) begin
      errors++; $display("FAIL hold_selrin: got %h need %h", dut_obs(), mdl_obs());
    end
  endtask

  task automatic test_same_edge();
    obs_t       o;
    logic [2:0] ta [4] = '{3'd4, 3'd4, 3'd4, 3'd4};
    logic       tw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] top[4] = '{2'd3, 2'd3, 2'd0, 2'd3};
    logic [7:0] tx [4] = '{8'h11, 8'h11, 8'h22, 8'h22};
    load_reg(3'd4, 8'h11);
    for (int i = 0; i < 4; i++) begin
      step(ta[i], 3'd4, 3'd4, tw[i], 1'b0, 1'b0, 1'b1, top[i], 8'h00);
      o = sb.pop_front();
      checks++;
      if (dut_obs() !== o || bus.data_out !== tx[i]) begin
        errors++; $display("FAIL same_edge%0d: got %h need %h (d=%h)", i, dut_obs(), o, tx[i]);
      end
    end
  endtask

  task automatic test_rin_overlap();
    obs_t o;
    // R_in holds 0x11 here; RF must capture the old value while R_in loads 0x77.
    step(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h77);
    read_reg(3'd0);
    o = sb.pop_front();
    checks++;
    if (dut_obs() !== o || bus.data_out !== 8'h11) begin
      errors++; $display("FAIL rin_old: got %h need %h", dut_obs(), o);
    end
    step(3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    read_reg(3'd1);
    o = sb.pop_front();
    checks++;
    if (dut_obs() !== o || bus.data_out !== 8'h77) begin
      errors++; $display("FAIL rin_new: got %h need %h", dut_obs(), o);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [3:0] s;
    for (int i = 0; i < 80; i++) begin
      s = 4'($urandom);
      step(3'($urandom), 3'($urandom), 3'($urandom), s[0], s[1], s[2], s[3],
           2'($urandom), 8'($urandom));
      if (s[3]) begin
        if (sb.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_empty%0d: got no entry need one", i);
        end else begin
          o = sb.pop_front();
          checks++;
          if (dut_obs() !== o) begin
            errors++; $display("FAIL b2b_out%0d: got %h need %h", i, dut_obs(), o);
          end
        end
      end else begin
        checks++;
        if (dut_obs() !== mdl_obs()) begin
          errors++; $display("FAIL b2b_hold%0d: got %h need %h", i, dut_obs(), mdl_obs());
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d left need 0", sb.size());
    end
  endtask

  initial begin
    bus.fld_A = '0; bus.fld_B = '0; bus.fld_C = '0;
    bus.ldRF = 1'b0; bus.selR_in = 1'b0; bus.ldR_in = 1'b0; bus.ldR_out = 1'b0;
    bus.alu_op = ALU_ADD; bus.data_in = '0;
    foreach (m_rf[i]) m_rf[i] = 8'h00;
    m_rin = 8'h00; m_rout = 8'h00; m_cy = 1'b0; m_neg = 1'b0; m_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_path();
    test_add_carry();
    test_sub();
    test_flag_hold();
    test_same_edge();
    test_rin_overlap();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
